// File: rtl/nn_sign_pkg.sv
// ---------------------------------------------------------------------------
// nn_sign_pkg
// Shared definitions for the sign-bit datapath of the neural-network core.
//   LANES_MAX  : widest supported sign vector (64 lanes)
//   sign_vec_t : sign vector at maximum width; narrower users slice it
//   SIGN_RST   : value loaded into sign registers on reset (all zeros)
// ---------------------------------------------------------------------------
package nn_sign_pkg;

    localparam int LANES_MAX = 64;

    typedef logic [LANES_MAX-1:0] sign_vec_t;

    localparam sign_vec_t SIGN_RST = '0;

endpackage : nn_sign_pkg

// File: rtl/mux_sign_bit_lane.sv
// ---------------------------------------------------------------------------
// mux_sign_bit_lane
// One lane of the sign-bit multiplexer: a pure combinational 2:1 select,
// optionally followed by a per-lane sign negation.
// Optional feature macro: MUX_SIGN_BIT_NEG_EN (adds input neg).
// Ports:
//   i0  : bit routed when s = 0
//   i1  : bit routed when s = 1
//   s   : select
//   neg : (MUX_SIGN_BIT_NEG_EN only) inverts the selected bit when 1
//   y   : lane result
// ---------------------------------------------------------------------------
module mux_sign_bit_lane (
    input  logic i0,
    input  logic i1,
    input  logic s,
`ifdef MUX_SIGN_BIT_NEG_EN
    input  logic neg,
`endif
    output logic y
);

    logic sel_bit;

    // Plain select: both data inputs feed the mux, no priority structure.
    assign sel_bit = s ? i1 : i0;

`ifdef MUX_SIGN_BIT_NEG_EN
    assign y = sel_bit ^ neg;
`else
    assign y = sel_bit;
`endif

endmodule : mux_sign_bit_lane

// File: rtl/mux_sign_bit.sv
// ---------------------------------------------------------------------------
// mux_sign_bit
// Lane-parallel 2:1 multiplexer for sign bits. The per-lane result is
// available combinationally (mux_out) and as a registered copy (mux_out_q)
// qualified by out_valid one cycle after an accepted in_valid.
// Optional feature macro: MUX_SIGN_BIT_NEG_EN (adds per-lane neg input).
// Parameters:
//   LANES     : number of independent lanes (1..64)
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (priority over in_valid)
//   i0, i1, s : per-lane data and select
//   neg       : (MUX_SIGN_BIT_NEG_EN only) per-lane negate
//   in_valid  : capture enable for the output register
//   mux_out   : combinational result
//   mux_out_q : registered result
//   out_valid : high for one cycle after each accepted vector
// ---------------------------------------------------------------------------
module mux_sign_bit
    import nn_sign_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] i0,
    input  logic [LANES-1:0] i1,
    input  logic [LANES-1:0] s,
`ifdef MUX_SIGN_BIT_NEG_EN
    input  logic [LANES-1:0] neg,
`endif
    input  logic             in_valid,
    output logic [LANES-1:0] mux_out,
    output logic [LANES-1:0] mux_out_q,
    output logic             out_valid
);

    localparam logic [LANES-1:0] RST_VAL = SIGN_RST[LANES-1:0];

    logic [LANES-1:0] q_reg;
    logic             valid_reg;

    // Lanes are fully independent; each is a separate select cell.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mux_sign_bit_lane u_lane (
                .i0  (i0[gi]),
                .i1  (i1[gi]),
                .s   (s[gi]),
`ifdef MUX_SIGN_BIT_NEG_EN
                .neg (neg[gi]),
`endif
                .y   (mux_out[gi])
            );
        end
    endgenerate

    // A vector presented while rst is high is dropped; data holds when idle,
    // while the valid flag is a one-cycle pulse per accepted vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg     <= RST_VAL;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                q_reg <= mux_out;
            end
        end
    end

    assign mux_out_q = q_reg;
    assign out_valid = valid_reg;

endmodule : mux_sign_bit

// File: tb/tb_mux_sign_bit.sv
// ---------------------------------------------------------------------------
// tb_mux_sign_bit
// Self-checking bench for mux_sign_bit (LANES = 4): directed steps followed
// by randomized vectors, compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_mux_sign_bit;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [L-1:0] i0, i1, s, neg;
    logic         in_valid;
    logic [L-1:0] mux_out, mux_out_q;
    logic         out_valid;

    // Reference state of the registered path.
    logic [L-1:0] exp_q;
    logic         exp_v;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    mux_sign_bit #(.LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .i0        (i0),
        .i1        (i1),
        .s         (s),
`ifdef MUX_SIGN_BIT_NEG_EN
        .neg       (neg),
`endif
        .in_valid  (in_valid),
        .mux_out   (mux_out),
        .mux_out_q (mux_out_q),
        .out_valid (out_valid)
    );

    // Lane rule: pick i1 when select is 1, else i0; flip when negated.
    function automatic logic [L-1:0] model(input logic [L-1:0] a0, a1, sel, ng);
        logic [L-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) begin
            r[k] = (sel[k] == 1'b1) ? a1[k] : a0[k];
`ifdef MUX_SIGN_BIT_NEG_EN
            r[k] = r[k] ^ ng[k];
`endif
        end
        return r;
    endfunction

    // Drive inputs and check only the combinational output (no clock edge).
    task automatic check_comb(input logic [L-1:0] a0, a1, sel, ng, input string tag);
        logic [L-1:0] e;
        i0 = a0; i1 = a1; s = sel; neg = ng;
        #1;
        e = model(a0, a1, sel, ng);
        tests++;
        assert (mux_out === e) else begin
            fails++;
            $error("FAIL %s mux_out: got %b expected %b", tag, mux_out, e);
        end
        $display("[TB] %s comb i0=%b i1=%b s=%b neg=%b -> %b", tag, a0, a1, sel, ng, mux_out);
    endtask

    // Full transaction: inputs, combinational check, one edge, registered check.
    task automatic apply(input logic [L-1:0] a0, a1, sel, ng,
                         input logic v, input logic r, input string tag);
        logic [L-1:0] e;
        rst = r; in_valid = v;
        check_comb(a0, a1, sel, ng, tag);
        e = model(a0, a1, sel, ng);
        @(posedge clk);
        if (r) begin
            exp_q = '0;
            exp_v = 1'b0;
        end else if (v) begin
            exp_q = e;
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        tests++;
        assert (mux_out_q === exp_q) else begin
            fails++;
            $error("FAIL %s mux_out_q: got %b expected %b", tag, mux_out_q, exp_q);
        end
        tests++;
        assert (out_valid === exp_v) else begin
            fails++;
            $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_v);
        end
        $display("[TB] %s rst=%b vld=%b -> q=%b out_valid=%b", tag, r, v, mux_out_q, out_valid);
    endtask

    initial begin
        logic [L-1:0] ra0, ra1, rs, rn;
        logic         rv, rr;

        rst = 1'b1; in_valid = 1'b0;
        i0 = '0; i1 = '0; s = '0; neg = '0;
        exp_q = '0; exp_v = 1'b0;

        // Reset with a pending vector: it must be dropped.
        apply(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, "reset_drop");
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "reset");

        // All-zero vector accepted.
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "zero");

        // s=1, i1=1, i0=0 held three cycles.
        for (int n = 0; n < 3; n++)
            apply(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, "sel_i1");

        // s=0, i0 changes with no clock edge in between.
        check_comb(4'b1111, 4'b0000, 4'b0000, 4'b0000, "sel_i0_hi");
        check_comb(4'b0000, 4'b0000, 4'b0000, 4'b0000, "sel_i0_lo");

        // Mixed lanes: s=1010, i0=0011, i1=1100 -> 1001.
        apply(4'b0011, 4'b1100, 4'b1010, 4'b0000, 1'b1, 1'b0, "mixed");

        // s toggling while idle changes only the combinational output.
        apply(4'b0011, 4'b1100, 4'b0101, 4'b0000, 1'b0, 1'b0, "idle_toggle");
        apply(4'b0011, 4'b1100, 4'b1111, 4'b0000, 1'b0, 1'b0, "idle_toggle2");

        // i0 == i1: result independent of s.
        apply(4'b0110, 4'b0110, 4'b1010, 4'b0000, 1'b1, 1'b0, "equal_a");
        apply(4'b0110, 4'b0110, 4'b0101, 4'b0000, 1'b1, 1'b0, "equal_b");

        // Reset mid-stream with in_valid high clears the register.
        apply(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, "pre_rst");
        apply(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, "mid_rst");
        apply(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "post_rst");

`ifdef MUX_SIGN_BIT_NEG_EN
        apply(4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0, "neg_on");
        apply(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, "neg_off");
        apply(4'b1010, 4'b0110, 4'b1100, 4'b0101, 1'b1, 1'b0, "neg_mix");
`endif

        // Randomized vectors with occasional reset.
        for (int n = 0; n < 200; n++) begin
            ra0 = L'($urandom);
            ra1 = L'($urandom);
            rs  = L'($urandom);
`ifdef MUX_SIGN_BIT_NEG_EN
            rn  = L'($urandom);
`else
            rn  = '0;
`endif
            rv  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 15) == 0);
            apply(ra0, ra1, rs, rn, rv, rr, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mux_sign_bit
